// File: rtl/dp_executor_pkg.sv
// dp_executor_pkg: shared constants for the datapath executor.
//   - opcode values carried in instruction[OPCODE_WIDTH-1:0]
//   - default field widths and the field offset helpers derived from them
//   - FSM state encoding
package dp_executor_pkg;

  localparam int DEF_OPCODE_WIDTH   = 4;
  localparam int DEF_MEM_ADDR_WIDTH = 12;
  localparam int DEF_RESULT_WIDTH   = 16;
  localparam int DEF_X_COORD_WIDTH  = 8;
  localparam int DEF_Y_COORD_WIDTH  = 7;
  localparam int DEF_COLOUR_WIDTH   = 3;

  localparam int OPCODE_NOP      = 0;
  localparam int OPCODE_MEMREAD  = 1;
  localparam int OPCODE_MEMWRITE = 2;
  localparam int OPCODE_DRAW     = 3;

  // Operand fields are packed LSB-first directly above the opcode.
  function automatic int addr_lsb(input int opw);
    return opw;
  endfunction

  function automatic int wdata_lsb(input int opw, input int aw);
    return opw + aw;
  endfunction

  function automatic int x_lsb(input int opw);
    return opw;
  endfunction

  function automatic int y_lsb(input int opw, input int xw);
    return opw + xw;
  endfunction

  function automatic int colour_lsb(input int opw, input int xw, input int yw);
    return opw + xw + yw;
  endfunction

  function automatic int plot_bit(input int opw, input int xw, input int yw, input int cw);
    return opw + xw + yw + cw;
  endfunction

  // Offsets for the default configuration.
  localparam int ADDR_LSB   = addr_lsb(DEF_OPCODE_WIDTH);
  localparam int WDATA_LSB  = wdata_lsb(DEF_OPCODE_WIDTH, DEF_MEM_ADDR_WIDTH);
  localparam int X_LSB      = x_lsb(DEF_OPCODE_WIDTH);
  localparam int Y_LSB      = y_lsb(DEF_OPCODE_WIDTH, DEF_X_COORD_WIDTH);
  localparam int COLOUR_LSB = colour_lsb(DEF_OPCODE_WIDTH, DEF_X_COORD_WIDTH, DEF_Y_COORD_WIDTH);
  localparam int PLOT_BIT   = plot_bit(DEF_OPCODE_WIDTH, DEF_X_COORD_WIDTH, DEF_Y_COORD_WIDTH,
                                       DEF_COLOUR_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/dp_instr_decode.sv
// dp_instr_decode: combinational instruction field extractor.
//   instruction : latched instruction word
//   opcode      : instruction[OPCODE_WIDTH-1:0]
//   addr, wdata : MEMREAD / MEMWRITE operands
//   x, y, colour, plot : DRAW operands
//   illegal     : opcode is none of NOP/MEMREAD/MEMWRITE/DRAW
// Fields overlap by opcode; the consumer only looks at the ones that apply.
module dp_instr_decode
  import dp_executor_pkg::*;
#(
  parameter int OPCODE_WIDTH      = DEF_OPCODE_WIDTH,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH    = DEF_MEM_ADDR_WIDTH,
  parameter int RESULT_WIDTH      = DEF_RESULT_WIDTH,
  parameter int X_COORD_WIDTH     = DEF_X_COORD_WIDTH,
  parameter int Y_COORD_WIDTH     = DEF_Y_COORD_WIDTH,
  parameter int COLOUR_WIDTH      = DEF_COLOUR_WIDTH
) (
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [MEM_ADDR_WIDTH-1:0]    addr,
  output logic [RESULT_WIDTH-1:0]      wdata,
  output logic [X_COORD_WIDTH-1:0]     x,
  output logic [Y_COORD_WIDTH-1:0]     y,
  output logic [COLOUR_WIDTH-1:0]      colour,
  output logic                         plot,
  output logic                         illegal
);

  localparam int A_LSB = addr_lsb(OPCODE_WIDTH);
  localparam int D_LSB = wdata_lsb(OPCODE_WIDTH, MEM_ADDR_WIDTH);
  localparam int X_OFF = x_lsb(OPCODE_WIDTH);
  localparam int Y_OFF = y_lsb(OPCODE_WIDTH, X_COORD_WIDTH);
  localparam int C_OFF = colour_lsb(OPCODE_WIDTH, X_COORD_WIDTH, Y_COORD_WIDTH);
  localparam int P_BIT = plot_bit(OPCODE_WIDTH, X_COORD_WIDTH, Y_COORD_WIDTH, COLOUR_WIDTH);

  assign opcode = instruction[OPCODE_WIDTH-1:0];
  assign addr   = instruction[A_LSB +: MEM_ADDR_WIDTH];
  assign wdata  = instruction[D_LSB +: RESULT_WIDTH];
  assign x      = instruction[X_OFF +: X_COORD_WIDTH];
  assign y      = instruction[Y_OFF +: Y_COORD_WIDTH];
  assign colour = instruction[C_OFF +: COLOUR_WIDTH];
  assign plot   = instruction[P_BIT];

  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OPCODE_WIDTH'(OPCODE_NOP),
      OPCODE_WIDTH'(OPCODE_MEMREAD),
      OPCODE_WIDTH'(OPCODE_MEMWRITE),
      OPCODE_WIDTH'(OPCODE_DRAW): illegal = 1'b0;
      default:                    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dp_executor.sv
// dp_executor: single-issue datapath executor shared by the draw/update
// micro-sequencers through the upstream arbiter.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   start            : level request; accepted once per high period (armed)
//   instruction      : captured on accept
//   finished         : 1 = idle / result valid, 0 = busy
//   result, error    : completion result (MEMREAD data else 0), illegal flag
//   mem_addr/wren/wdata, mem_rdata : synchronous game-state RAM port
//   vga_x/y/colour/plot            : VGA adapter pixel port
// Optional build macro DP_EXECUTOR_DRAW_CLIP_EN: DRAW outside
// SCREEN_W x SCREEN_H suppresses the plot strobe and flags error.
module dp_executor
  import dp_executor_pkg::*;
#(
  parameter int OPCODE_WIDTH      = DEF_OPCODE_WIDTH,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH    = DEF_MEM_ADDR_WIDTH,
  parameter int RESULT_WIDTH      = DEF_RESULT_WIDTH,
  parameter int X_COORD_WIDTH     = DEF_X_COORD_WIDTH,
  parameter int Y_COORD_WIDTH     = DEF_Y_COORD_WIDTH,
  parameter int COLOUR_WIDTH      = DEF_COLOUR_WIDTH,
  parameter int MEM_LATENCY       = 2,
  parameter int SCREEN_W          = 160,
  parameter int SCREEN_H          = 120
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result,
  output logic                         error,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
  output logic                         mem_wren,
  output logic [RESULT_WIDTH-1:0]      mem_wdata,
  input  logic [RESULT_WIDTH-1:0]      mem_rdata,
  output logic [X_COORD_WIDTH-1:0]     vga_x,
  output logic [Y_COORD_WIDTH-1:0]     vga_y,
  output logic [COLOUR_WIDTH-1:0]      vga_colour,
  output logic                         vga_plot
);

`ifdef DP_EXECUTOR_DRAW_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam int CNT_W = 3;  // MEM_LATENCY is 1..7

  state_t                         state, state_nxt;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q;
  logic                           armed;
  logic [CNT_W-1:0]               lat_cnt;
  logic [RESULT_WIDTH-1:0]        rdata_q;
  logic                           err_pend;

  logic [OPCODE_WIDTH-1:0]        dec_op;
  logic [MEM_ADDR_WIDTH-1:0]      dec_addr;
  logic [RESULT_WIDTH-1:0]        dec_wdata;
  logic [X_COORD_WIDTH-1:0]       dec_x;
  logic [Y_COORD_WIDTH-1:0]       dec_y;
  logic [COLOUR_WIDTH-1:0]        dec_colour;
  logic                           dec_plot;
  logic                           dec_illegal;

  logic is_read, is_write, is_draw;
  logic draw_oob, clip_hit, accept;

  dp_instr_decode #(
    .OPCODE_WIDTH      (OPCODE_WIDTH),
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .MEM_ADDR_WIDTH    (MEM_ADDR_WIDTH),
    .RESULT_WIDTH      (RESULT_WIDTH),
    .X_COORD_WIDTH     (X_COORD_WIDTH),
    .Y_COORD_WIDTH     (Y_COORD_WIDTH),
    .COLOUR_WIDTH      (COLOUR_WIDTH)
  ) u_decode (
    .instruction (instr_q),
    .opcode      (dec_op),
    .addr        (dec_addr),
    .wdata       (dec_wdata),
    .x           (dec_x),
    .y           (dec_y),
    .colour      (dec_colour),
    .plot        (dec_plot),
    .illegal     (dec_illegal)
  );

  assign is_read  = (dec_op == OPCODE_WIDTH'(OPCODE_MEMREAD));
  assign is_write = (dec_op == OPCODE_WIDTH'(OPCODE_MEMWRITE));
  assign is_draw  = (dec_op == OPCODE_WIDTH'(OPCODE_DRAW));

  assign draw_oob = (32'(dec_x) >= SCREEN_W) || (32'(dec_y) >= SCREEN_H);
  assign clip_hit = CLIP_EN && draw_oob;

  assign accept = (state == ST_IDLE) && start && armed;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the RAM/VGA strobes. Strobes are decoded from state so
  // they land in the DECODE cycle itself; gating with reset stops a pending
  // write/plot in the very cycle reset is raised.
  always_comb begin
    state_nxt  = state;
    mem_addr   = '0;
    mem_wren   = 1'b0;
    mem_wdata  = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_DECODE;
      ST_DECODE: begin
        state_nxt = is_read ? ST_MEM_WAIT : ST_DONE;
        if (!reset) begin
          if (is_read || is_write) mem_addr = dec_addr;
          if (is_write) begin
            mem_wren  = 1'b1;
            mem_wdata = dec_wdata;
          end
          if (is_draw) begin
            vga_x      = dec_x;
            vga_y      = dec_y;
            vga_colour = dec_colour;
            vga_plot   = dec_plot && !clip_hit;
          end
        end
      end
      ST_MEM_WAIT: begin
        // Address held for the whole wait so a pipelined RAM stays coherent.
        if (!reset) mem_addr = dec_addr;
        if (lat_cnt == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q  <= '0;
      finished <= 1'b1;
      result   <= '0;
      error    <= 1'b0;
      armed    <= 1'b1;
      lat_cnt  <= '0;
      rdata_q  <= '0;
      err_pend <= 1'b0;
    end else begin
      // Re-arm only on a sampled low start so a held request runs once.
      if (!start) armed <= 1'b1;
      case (state)
        ST_IDLE: if (accept) begin
          instr_q  <= instruction;
          finished <= 1'b0;
          armed    <= 1'b0;
          error    <= 1'b0;
        end
        ST_DECODE: begin
          lat_cnt  <= CNT_W'(MEM_LATENCY);
          rdata_q  <= '0;
          err_pend <= dec_illegal || (is_draw && clip_hit);
        end
        ST_MEM_WAIT: begin
          // Counter hits 0 on this edge: read data is valid now.
          lat_cnt <= lat_cnt - CNT_W'(1);
          if (lat_cnt == CNT_W'(1)) rdata_q <= mem_rdata;
        end
        ST_DONE: begin
          finished <= 1'b1;
          result   <= rdata_q;
          error    <= err_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_executor.sv
// tb_dp_executor: directed bench for dp_executor with a pipelined RAM model.
module tb_dp_executor;

  localparam int L = 2;

  logic        clock, reset, start;
  logic [31:0] instruction;
  logic        finished, error, mem_wren, vga_plot;
  logic [15:0] result, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  int tests, fails;

  // RAM model: address sampled each edge, data out L edges later.
  logic [15:0] ram [0:4095];
  logic [15:0] rd_pipe [0:L-1];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [15:0] bd_data;

  // Observations from run_instr
  int          obs_lat, obs_wren, obs_plot;
  logic [11:0] obs_addr0, obs_waddr;
  logic [15:0] obs_wdata;
  logic [7:0]  obs_x;
  logic [6:0]  obs_y;
  logic [2:0]  obs_c;
  logic        obs_err0;

  dp_executor #(.MEM_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .start(start), .instruction(instruction),
    .finished(finished), .result(result), .error(error),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    else if (bd_we) ram[bd_addr] <= bd_data;
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  function automatic logic [31:0] i_read(input logic [11:0] a);
    return {16'h0, a, 4'd1};
  endfunction
  function automatic logic [31:0] i_write(input logic [11:0] a, input logic [15:0] d);
    return {d, a, 4'd2};
  endfunction
  function automatic logic [31:0] i_draw(input logic [7:0] x, input logic [6:0] y,
                                         input logic [2:0] c, input logic p);
    return {9'h0, p, c, y, x, 4'd3};
  endfunction

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    @(negedge clock); bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock); bd_we = 1'b0;
  endtask

  // Issue one instruction (start held 2 cycles), scramble the instruction
  // bus while busy, and record strobes until finished rises. k counts edges
  // after the accept edge; k=0 is the DECODE cycle.
  task automatic run_instr(input logic [31:0] instr);
    obs_lat = -1; obs_wren = 0; obs_plot = 0; obs_addr0 = '0; obs_waddr = '0;
    obs_wdata = '0; obs_x = '0; obs_y = '0; obs_c = '0; obs_err0 = 1'b0;
    @(negedge clock); start = 1'b1; instruction = instr;
    @(posedge clock);
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (k == 0) begin
        obs_addr0 = mem_addr; obs_err0 = error; instruction = ~instr;
      end
      if (k == 1) start = 1'b0;
      if (mem_wren) begin obs_wren++; obs_waddr = mem_addr; obs_wdata = mem_wdata; end
      if (vga_plot) begin obs_plot++; obs_x = vga_x; obs_y = vga_y; obs_c = vga_colour; end
      if (finished) begin obs_lat = k; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (finished !== 1'b1) begin fails++; $display("FAIL reset_finished got %0b exp 1", finished); end
    tests++; if (result !== 16'h0) begin fails++; $display("FAIL reset_result got %0h exp 0", result); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %0b exp 0", error); end
    tests++; if (mem_wren !== 1'b0 || mem_addr !== 12'h0 || mem_wdata !== 16'h0) begin
      fails++; $display("FAIL reset_mem got wren=%0b addr=%0h data=%0h exp 0", mem_wren, mem_addr, mem_wdata); end
    tests++; if (vga_plot !== 1'b0 || vga_x !== 8'h0 || vga_y !== 7'h0 || vga_colour !== 3'h0) begin
      fails++; $display("FAIL reset_vga got plot=%0b x=%0h y=%0h c=%0h exp 0", vga_plot, vga_x, vga_y, vga_colour); end
  endtask

  task automatic test_memread();
    run_instr(i_read(12'h010));
    tests++; if (obs_addr0 !== 12'h010) begin fails++; $display("FAIL rd_addr got %0h exp 010", obs_addr0); end
    tests++; if (obs_lat != 2 + L) begin fails++; $display("FAIL rd_latency got %0d exp %0d", obs_lat, 2 + L); end
    tests++; if (result !== 16'hBEEF) begin fails++; $display("FAIL rd_result got %0h exp beef", result); end
    tests++; if (error !== 1'b0 || obs_wren != 0) begin fails++; $display("FAIL rd_side got err=%0b wren=%0d exp 0/0", error, obs_wren); end
  endtask

  task automatic test_memwrite();
    run_instr(i_write(12'h3FF, 16'h1234));
    tests++; if (obs_wren != 1) begin fails++; $display("FAIL wr_pulses got %0d exp 1", obs_wren); end
    tests++; if (obs_waddr !== 12'h3FF || obs_wdata !== 16'h1234) begin
      fails++; $display("FAIL wr_fields got %0h/%0h exp 3ff/1234", obs_waddr, obs_wdata); end
    tests++; if (obs_lat != 2 || result !== 16'h0) begin fails++; $display("FAIL wr_done got lat=%0d res=%0h exp 2/0", obs_lat, result); end
    run_instr(i_read(12'h3FF));
    tests++; if (result !== 16'h1234) begin fails++; $display("FAIL wr_readback got %0h exp 1234", result); end
  endtask

  task automatic test_draw();
    run_instr(i_draw(8'd5, 7'd7, 3'b100, 1'b1));
    tests++; if (obs_plot != 1) begin fails++; $display("FAIL draw_pulses got %0d exp 1", obs_plot); end
    tests++; if (obs_x !== 8'd5 || obs_y !== 7'd7 || obs_c !== 3'd4) begin
      fails++; $display("FAIL draw_fields got %0d/%0d/%0d exp 5/7/4", obs_x, obs_y, obs_c); end
    tests++; if (obs_lat != 2 || result !== 16'h0) begin fails++; $display("FAIL draw_done got lat=%0d res=%0h exp 2/0", obs_lat, result); end
    run_instr(i_draw(8'd5, 7'd7, 3'b100, 1'b0));
    tests++; if (obs_plot != 0 || obs_lat != 2) begin fails++; $display("FAIL draw_noplot got plot=%0d lat=%0d exp 0/2", obs_plot, obs_lat); end
  endtask

  task automatic test_start_held();
    int falls;
    logic prev;
    falls = 0; prev = finished;
    @(negedge clock); start = 1'b1; instruction = 32'h0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (prev && !finished) falls++;
      prev = finished;
      if (c == 9) start = 1'b0;
    end
    tests++; if (falls != 1 || finished !== 1'b1) begin fails++; $display("FAIL held_once got execs=%0d fin=%0b exp 1/1", falls, finished); end
    run_instr(32'h0);
    tests++; if (obs_lat != 2) begin fails++; $display("FAIL held_rearm got lat=%0d exp 2", obs_lat); end
  endtask

  task automatic test_illegal();
    run_instr(32'h0000_000F);
    tests++; if (error !== 1'b1 || result !== 16'h0 || obs_lat != 2) begin
      fails++; $display("FAIL illegal got err=%0b res=%0h lat=%0d exp 1/0/2", error, result, obs_lat); end
    run_instr(32'h0);
    tests++; if (obs_err0 !== 1'b0) begin fails++; $display("FAIL illegal_clear got %0b exp 0", obs_err0); end
  endtask

  // Start rises while the read is in DONE; accept must wait for IDLE.
  task automatic test_done_rise();
    @(negedge clock); start = 1'b1; instruction = i_read(12'h010);
    @(posedge clock);
    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 3) start = 1'b1;
      if (k == 4) begin
        tests++; if (finished !== 1'b1) begin fails++; $display("FAIL done_rise_idle got %0b exp 1", finished); end
      end
      if (k == 5) begin
        tests++; if (finished !== 1'b0) begin fails++; $display("FAIL done_rise_accept got %0b exp 0", finished); end
      end
      if (k == 6) start = 1'b0;
      if (k == 12) begin
        tests++; if (finished !== 1'b1 || result !== 16'hBEEF) begin
          fails++; $display("FAIL done_rise_result got fin=%0b res=%0h exp 1/beef", finished, result); end
      end
      @(posedge clock);
    end
  endtask

  task automatic test_reset_mid();
    run_instr(i_read(12'h010));
    @(negedge clock); start = 1'b1; instruction = i_read(12'h010);
    @(posedge clock);
    @(negedge clock);             // DECODE
    @(posedge clock);
    @(negedge clock);             // MEM_WAIT
    reset = 1'b1; start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    tests++; if (finished !== 1'b1 || result !== 16'h0 || error !== 1'b0) begin
      fails++; $display("FAIL reset_memwait got fin=%0b res=%0h err=%0b exp 1/0/0", finished, result, error); end
    tests++; if (mem_addr !== 12'h0 || mem_wren !== 1'b0 || vga_plot !== 1'b0) begin
      fails++; $display("FAIL reset_memwait_out got addr=%0h wren=%0b plot=%0b exp 0", mem_addr, mem_wren, vga_plot); end
    reset = 1'b0;
    // Reset raised in the DECODE cycle of a write: the strobe must die now.
    @(negedge clock); start = 1'b1; instruction = i_write(12'h020, 16'hAAAA);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1; start = 1'b0;
    #1;
    tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL reset_decode_wren got %0b exp 0", mem_wren); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tests++; if (ram[12'h020] !== 16'h5555 || finished !== 1'b1) begin
      fails++; $display("FAIL reset_decode_ram got %0h fin=%0b exp 5555/1", ram[12'h020], finished); end
  endtask

  task automatic test_clip();
    run_instr(i_draw(8'd160, 7'd0, 3'b010, 1'b1));
`ifdef DP_EXECUTOR_DRAW_CLIP_EN
    tests++; if (obs_plot != 0 || error !== 1'b1 || obs_lat != 2) begin
      fails++; $display("FAIL clip got plot=%0d err=%0b lat=%0d exp 0/1/2", obs_plot, error, obs_lat); end
`else
    tests++; if (obs_plot != 1 || obs_x !== 8'd160 || error !== 1'b0 || obs_lat != 2) begin
      fails++; $display("FAIL noclip got plot=%0d x=%0d err=%0b lat=%0d exp 1/160/0/2", obs_plot, obs_x, error, obs_lat); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; start = 1'b0; instruction = 32'h0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    preload(12'h010, 16'hBEEF);
    preload(12'h020, 16'h5555);
    @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_memread();
    test_memwrite();
    test_draw();
    test_start_held();
    test_illegal();
    test_done_rise();
    test_reset_mid();
    test_clip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
